// File: rtl/mdu_issue_ctrl.sv
// E-stage issue controller for the multiply/divide unit: single-issue guarantee, stalls, mfhi/mflo return.
// Optional busy watchdog enabled by defining MDU_WATCHDOG_EN.
module mdu_issue_ctrl #(
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
`ifdef MDU_WATCHDOG_EN
  , parameter int unsigned WD_SLACK = 2
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        e_valid,
  input  logic [4:0]  e_op,
  input  logic [31:0] e_a,
  input  logic [31:0] e_b,
  input  logic        e_advance,
  input  logic        d_md,
  input  logic        int_exc_req,
  input  logic        mdu_busy,
  input  logic [31:0] mdu_result,
  output logic [4:0]  mdu_op,
  output logic [31:0] mdu_a,
  output logic [31:0] mdu_b,
  output logic        stall_e,
  output logic        stall_d,
  output logic [31:0] md_result,
  output logic        md_result_valid,
  output logic        wd_err
);

  localparam int unsigned MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [4:0] OP_NONE  = 5'd0;
  localparam logic [4:0] OP_MULT  = 5'd1;
  localparam logic [4:0] OP_MULTU = 5'd2;
  localparam logic [4:0] OP_DIV   = 5'd3;
  localparam logic [4:0] OP_DIVU  = 5'd4;
  localparam logic [4:0] OP_MFHI  = 5'd7;
  localparam logic [4:0] OP_MFLO  = 5'd8;
  localparam logic [4:0] OP_MSUB  = 5'd9;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_issued, w_issued_nxt;

  logic w_is_md, w_is_mul, w_is_div, w_is_mf;
  logic w_want, w_go, w_stall_e;

  // Op decode; out-of-range codes fall through as NONE.
  assign w_is_md  = (e_op >= OP_MULT) && (e_op <= OP_MSUB);
  assign w_is_mul = (e_op == OP_MULT) || (e_op == OP_MULTU) || (e_op == OP_MSUB);
  assign w_is_div = (e_op == OP_DIV) || (e_op == OP_DIVU);
  assign w_is_mf  = (e_op == OP_MFHI) || (e_op == OP_MFLO);

  // reset gates want so every combinational output is zero while reset is low.
  assign w_want    = reset & e_valid & w_is_md & ~r_issued;
  assign w_go      = w_want & ~mdu_busy & (r_cnt == '0) & ~int_exc_req;
  assign w_stall_e = w_want & ~w_go & ~int_exc_req;

  assign mdu_op          = w_go ? e_op : OP_NONE;
  assign mdu_a           = w_go ? e_a : 32'd0;
  assign mdu_b           = w_go ? e_b : 32'd0;
  assign stall_e         = w_stall_e;
  assign stall_d         = w_stall_e | (d_md & ((r_state == ST_RUN) | (w_go & (w_is_mul | w_is_div))));
  assign md_result_valid = w_go & w_is_mf;
  assign md_result       = (w_go & w_is_mf) ? mdu_result : 32'd0;

  // Shadow latency counter: loads on mult/div issue, pauses while the MDU is frozen.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_go & w_is_mul) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = CNT_W'(MUL_LAT);
        end else if (w_go & w_is_div) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = CNT_W'(DIV_LAT);
        end
      end
      ST_RUN: begin
        if (!int_exc_req) begin
          if (r_cnt <= CNT_W'(1)) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Held E instruction remembers it already issued until it leaves or is flushed.
  always_comb begin
    w_issued_nxt = r_issued;
    if (e_advance | int_exc_req) begin
      w_issued_nxt = 1'b0;
    end else if (w_go) begin
      w_issued_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_issued <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_issued <= w_issued_nxt;
    end
  end

`ifdef MDU_WATCHDOG_EN
  localparam int unsigned WD_LIM = MAX_LAT + WD_SLACK;
  localparam int unsigned WD_W   = $clog2(WD_LIM + 2);

  logic [WD_W-1:0] r_busy_run, r_idle_busy, r_last_lat;
  logic [WD_W-1:0] w_run_inc, w_idle_inc;
  logic            r_wd, w_wd_trip;

  // Saturating increments; the saturation value is always past any trip threshold.
  assign w_run_inc  = (&r_busy_run) ? r_busy_run : r_busy_run + WD_W'(1);
  assign w_idle_inc = (&r_idle_busy) ? r_idle_busy : r_idle_busy + WD_W'(1);

  // Frozen cycles do not count toward the busy run, matching the paused shadow counter.
  assign w_wd_trip = mdu_busy &
                     ((~int_exc_req & ({1'b0, w_run_inc} > ({1'b0, r_last_lat} + (WD_W+1)'(WD_SLACK)))) |
                      ((r_state == ST_IDLE) & (w_idle_inc > WD_W'(WD_SLACK))));

  assign wd_err = reset & (r_wd | w_wd_trip);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy_run  <= '0;
      r_idle_busy <= '0;
      r_last_lat  <= '0;
      r_wd        <= 1'b0;
    end else begin
      if (!mdu_busy) begin
        r_busy_run <= '0;
      end else if (!int_exc_req) begin
        r_busy_run <= w_run_inc;
      end
      r_idle_busy <= (mdu_busy & (r_state == ST_IDLE)) ? w_idle_inc : '0;
      if (w_go & w_is_mul) begin
        r_last_lat <= WD_W'(MUL_LAT);
      end else if (w_go & w_is_div) begin
        r_last_lat <= WD_W'(DIV_LAT);
      end
      r_wd <= r_wd | w_wd_trip;
    end
  end
`else
  assign wd_err = 1'b0;
`endif

endmodule
